// File: rtl/serial_rx_buffer_pkg.sv
// Shared definitions for the serial receive buffer and its FIFO.
package serial_rx_buffer_pkg;

  // Bit positions inside the 3-bit sticky error vector.
  localparam int unsigned ERR_OVERFLOW = 2;
  localparam int unsigned ERR_FRAME    = 1;
  localparam int unsigned ERR_PARITY   = 0;
  localparam int unsigned ERR_BITS     = 3;

  // One FIFO entry holds {frame, parity, data}.
  function automatic int unsigned entry_width(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/serial_fifo_sync.sv
// Generic synchronous show-ahead FIFO; shared by the RX and TX paths.
module serial_fifo_sync #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       w_en,
  output logic                       full,
  output logic [WIDTH-1:0]           r_data,
  input  logic                       r_en,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;

  assign push   = w_en & ~full;
  assign pop    = r_en & ~empty;
  assign full   = (count == LW'(DEPTH));
  assign empty  = (count == '0);
  assign level  = count;
  assign r_data = mem[rd_ptr];

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

endmodule

// File: rtl/serial_rx_buffer.sv
// Receive buffer: queues words from serial_rx with their error flags,
// keeps sticky error status and raises irq on fill level or error.
module serial_rx_buffer
  import serial_rx_buffer_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned THRESHOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_BITS-1:0]     rx_data,
  input  logic                     rx_err_overflow,
  input  logic                     rx_err_frame,
  input  logic                     rx_err_parity,
  input  logic                     rx_rdy,
  output logic                     rx_ack,
  output logic [DATA_BITS-1:0]     r_data,
  output logic                     r_err_frame,
  output logic                     r_err_parity,
  output logic                     r_rdy,
  input  logic                     r_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic [2:0]               err_sticky,
  input  logic [2:0]               err_clr,
  output logic                     irq
);

  localparam int unsigned EW = entry_width(DATA_BITS);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [LW-1:0] level_nx;
  logic [2:0]    err_set;
  logic [2:0]    err_nx;

  assign rx_ack = ~rst & ~full;
  assign push   = rx_rdy & rx_ack;
  assign r_rdy  = ~empty;
  assign pop    = r_ack & r_rdy;

  serial_fifo_sync #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .w_data ({rx_err_frame, rx_err_parity, rx_data}),
    .w_en   (push),
    .full   (full),
    .r_data (head),
    .r_en   (r_ack),
    .empty  (empty),
    .level  (level)
  );

  assign r_err_frame  = head[EW-1];
  assign r_err_parity = head[EW-2];
  assign r_data       = head[DATA_BITS-1:0];

  // Next-state occupancy and sticky errors; a same-cycle set beats a clear.
  always_comb begin
    level_nx = level;
    if (push && !pop)      level_nx = level + LW'(1);
    else if (pop && !push) level_nx = level - LW'(1);

    err_set = '0;
    if (push) begin
      err_set[ERR_OVERFLOW] = rx_err_overflow;
      err_set[ERR_FRAME]    = rx_err_frame;
      err_set[ERR_PARITY]   = rx_err_parity;
    end
    err_nx = (err_sticky & ~err_clr) | err_set;
  end

  // Sticky error register and irq, both from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= '0;
      irq        <= 1'b0;
    end else begin
      err_sticky <= err_nx;
      irq        <= (level_nx >= LW'(THRESHOLD)) | (|err_nx);
    end
  end

endmodule

// File: tb/tb_serial_rx_buffer.sv
// Self-checking bench for serial_rx_buffer: vector table plus scoreboard.
module tb_serial_rx_buffer;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned THRESHOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_err_overflow = 1'b0;
  logic       rx_err_frame = 1'b0;
  logic       rx_err_parity = 1'b0;
  logic       rx_rdy = 1'b0;
  logic       rx_ack;
  logic [7:0] r_data;
  logic       r_err_frame;
  logic       r_err_parity;
  logic       r_rdy;
  logic       r_ack = 1'b0;
  logic [4:0] level;
  logic [2:0] err_sticky;
  logic [2:0] err_clr = '0;
  logic       irq;

  serial_rx_buffer #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .THRESHOLD (THRESHOLD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_err_overflow (rx_err_overflow),
    .rx_err_frame    (rx_err_frame),
    .rx_err_parity   (rx_err_parity),
    .rx_rdy          (rx_rdy),
    .rx_ack          (rx_ack),
    .r_data          (r_data),
    .r_err_frame     (r_err_frame),
    .r_err_parity    (r_err_parity),
    .r_rdy           (r_rdy),
    .r_ack           (r_ack),
    .level           (level),
    .err_sticky      (err_sticky),
    .err_clr         (err_clr),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboard of expected entries {frame, parity, data} and sticky model.
  logic [9:0] sb_q[$];
  logic [2:0] m_err = '0;

  typedef struct {
    logic       rdy;
    logic [7:0] d;
    logic       ovf;
    logic       fr;
    logic       par;
    logic       ack;
    logic [2:0] clr;
    logic [4:0] exp_level;
    logic [9:0] exp_head;
    logic [2:0] exp_err;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, score the handshakes, then check after the edge.
  task automatic cycle(input logic rdy, input logic [7:0] d, input logic ovf,
                       input logic fr, input logic par, input logic ack,
                       input logic [2:0] clr);
    logic acc;
    logic popd;
    int   n;
    rx_rdy = rdy; rx_data = d; rx_err_overflow = ovf;
    rx_err_frame = fr; rx_err_parity = par; r_ack = ack; err_clr = clr;
    #1;
    acc  = rx_rdy & rx_ack;
    popd = r_rdy & r_ack;
    if (popd) begin
      if (sb_q.size() == 0) begin
        check("pop_on_empty_model", 32'd1, 32'd0);
      end else begin
        check("pop_data", 32'({r_err_frame, r_err_parity, r_data}), 32'(sb_q[0]));
        void'(sb_q.pop_front());
      end
    end
    m_err = (m_err & ~clr) | (acc ? {ovf, fr, par} : 3'b000);
    if (acc) sb_q.push_back({fr, par, d});
    @(posedge clk);
    #1;
    n = sb_q.size();
    check("level", 32'(level), 32'(n));
    check("r_rdy", 32'(r_rdy), (n != 0) ? 32'd1 : 32'd0);
    check("err_sticky", 32'(err_sticky), 32'(m_err));
    check("irq", 32'(irq), ((n >= int'(THRESHOLD)) || (m_err != 3'b000)) ? 32'd1 : 32'd0);
    if (n != 0 && r_rdy)
      check("head", 32'({r_err_frame, r_err_parity, r_data}), 32'(sb_q[0]));
  endtask

  task automatic idle_pop();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
  endtask

  initial begin
    // rdy, d, ovf, fr, par, ack, clr, exp_level, exp_head, exp_err, exp_irq
    vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd1, 10'h041, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd2, 10'h041, 3'b000, 1'b0};
    vecs[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd3, 10'h041, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd2, 10'h042, 3'b000, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd1, 10'h043, 3'b000, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 10'h000, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd1, 10'h155, 3'b001, 1'b1};
    vecs[7]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd2, 10'h155, 3'b001, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd1, 10'h066, 3'b001, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 5'd1, 10'h066, 3'b000, 1'b0};
    vecs[10] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 5'd2, 10'h066, 3'b010, 1'b1};
    vecs[11] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd3, 10'h066, 3'b100, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 5'd3, 10'h066, 3'b000, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd2, 10'h277, 3'b000, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd1, 10'h012, 3'b000, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 10'h000, 3'b000, 1'b0};

    // Power-on reset
    @(posedge clk); #1;
    check("rx_ack_in_reset", 32'(rx_ack), 32'd0);
    @(posedge clk); #1;
    check("reset_level", 32'(level), 32'd0);
    check("reset_r_rdy", 32'(r_rdy), 32'd0);
    check("reset_err", 32'(err_sticky), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    #1;
    check("rx_ack_after_reset", 32'(rx_ack), 32'd1);

    // Vector table: basic ordering, error flags, sticky set/clear
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].rdy, vecs[i].d, vecs[i].ovf, vecs[i].fr, vecs[i].par,
            vecs[i].ack, vecs[i].clr);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_err", i), 32'(err_sticky), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      if (vecs[i].exp_level != 5'd0)
        check($sformatf("vec%0d_head", i), 32'({r_err_frame, r_err_parity, r_data}),
              32'(vecs[i].exp_head));
    end

    // Fill to full across a pointer wrap; 17th word waits for a pop
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      if (i == 14) check("rx_ack_before_full", 32'(rx_ack), 32'd1);
    end
    check("full_level", 32'(level), 32'd16);
    check("rx_ack_full", 32'(rx_ack), 32'd0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    check("held_level", 32'(level), 32'd16);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    check("full_pop_no_push", 32'(level), 32'd15);
    check("rx_ack_reopens", 32'(rx_ack), 32'd1);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    check("17th_accepted", 32'(level), 32'd16);
    check("rx_ack_full_again", 32'(rx_ack), 32'd0);
    for (int i = 0; i < 16; i++) idle_pop();
    check("drained", 32'(level), 32'd0);

    // Threshold edge for irq and push+pop at threshold
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    check("irq_below_threshold", 32'(irq), 32'd0);
    cycle(1'b1, 8'h17, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    check("irq_at_threshold", 32'(irq), 32'd1);
    cycle(1'b1, 8'h18, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    check("pushpop_level", 32'(level), 32'd8);
    check("pushpop_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) idle_pop();
    check("irq_drops", 32'(irq), 32'd0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    check("pre_reset_level", 32'(level), 32'd5);
    check("pre_reset_err", 32'(err_sticky), 32'b010);

    // Reset mid-operation with upstream still offering data
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'hEE; r_ack = 1'b0; err_clr = 3'b000;
    #1;
    check("rx_ack_mid_reset", 32'(rx_ack), 32'd0);
    @(posedge clk); #1;
    check("mid_reset_level", 32'(level), 32'd0);
    check("mid_reset_r_rdy", 32'(r_rdy), 32'd0);
    check("mid_reset_err", 32'(err_sticky), 32'd0);
    check("mid_reset_irq", 32'(irq), 32'd0);
    rst = 1'b0; rx_rdy = 1'b0;
    #1;
    check("rx_ack_post_reset", 32'(rx_ack), 32'd1);
    sb_q.delete();
    m_err = '0;
    cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    check("post_reset_head", 32'(r_data), 32'hAB);
    idle_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
